// File: rtl/ahbl_pkg.sv
// ahbl_pkg
//   Shared encodings for the AHB-Lite command master: command opcodes,
//   AHB-Lite transfer/burst/protection constants, the engine state type and
//   a helper that derives HSIZE from the data bus width.
package ahbl_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_READ  = 2'b01,
        CMD_POLL  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_op_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_e;

    // Only 32- and 64-bit buses are supported.
    function automatic logic [2:0] hsize_for(input int unsigned dw);
        return (dw >= 64) ? 3'b011 : 3'b010;
    endfunction

endpackage

// File: rtl/ahbl_cmd_fifo.sv
// ahbl_cmd_fifo
//   Synchronous single-clock FIFO holding packed commands.
//   Ports:
//     clk, rst       rising-edge clock, synchronous active-high reset
//     push, wr_data  write request and data (ignored when full)
//     pop, rd_data   read request (ignored when empty); rd_data shows the head
//     full, empty    status derived from the registered occupancy count
//     count          number of stored entries, 0..DEPTH
module ahbl_cmd_fifo
    import ahbl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master
//   AHB-Lite master executing queued write / read / masked-poll commands,
//   one non-overlapping SINGLE transfer at a time.
//   Ports:
//     SYSCLK, SYSRST            clock, synchronous active-high reset
//     CMD_VALID/READY/OP/ADDR/DATA/MASK   command push interface
//     RSP_VALID/DATA/ERR/TIMEOUT          one-cycle completion report
//     BUSY                      queue non-empty or engine active
//     HADDR..HWDATA, HSEL       AHB-Lite master outputs (all registered)
//     HRDATA, HREADY, HRESP     AHB-Lite slave responses
module ahbl_cmd_master
    import ahbl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_MAX   = 255
) (
    input  logic                  SYSCLK,
    input  logic                  SYSRST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_OP,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_DATA,
    input  logic [DATA_WIDTH-1:0] CMD_MASK,
    output logic                  RSP_VALID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic                  BUSY,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic [NUM_SLAVES-1:0] HSEL,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int FW    = 2 + ADDR_WIDTH + 2 * DATA_WIDTH;
    localparam int SW    = $clog2(NUM_SLAVES);
    localparam int QCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = ($clog2(POLL_MAX + 1) > 8) ? $clog2(POLL_MAX + 1) : 8;
    localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);

    state_e                 state;
    cmd_op_e                w_op;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [DATA_WIDTH-1:0]  w_mask;
    logic [CNT_W-1:0]       attempts;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [QCW-1:0]         fifo_count;
    logic [FW-1:0]          fifo_rd;

    logic [1:0]             head_op;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [DATA_WIDTH-1:0]  head_mask;

    logic                   poll_match;
    logic                   poll_last;
    logic                   poll_retry;

    assign CMD_READY = !fifo_full;
    assign fifo_push = CMD_VALID && CMD_READY;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign BUSY      = (fifo_count != '0) || (state != ST_IDLE);

    assign {head_op, head_addr, head_data, head_mask} = fifo_rd;

    ahbl_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (SYSCLK),
        .rst     (SYSRST),
        .push    (fifo_push),
        .wr_data ({CMD_OP, CMD_ADDR, CMD_DATA, CMD_MASK}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign HBURST    = HBURST_SINGLE;
    assign HSIZE     = hsize_for(DATA_WIDTH);
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;

    assign poll_match = ((HRDATA ^ w_data) & w_mask) == '0;
    assign poll_last  = (attempts == CNT_W'(POLL_MAX));
    assign poll_retry = (w_op == CMD_POLL) && !poll_match && !HRESP && !poll_last;

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            state       <= ST_IDLE;
            w_op        <= CMD_WRITE;
            w_data      <= '0;
            w_mask      <= '0;
            attempts    <= '0;
            HADDR       <= '0;
            HTRANS      <= HTRANS_IDLE;
            HWRITE      <= 1'b0;
            HSEL        <= '0;
            HWDATA      <= '0;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        w_op     <= cmd_op_e'(head_op);
                        w_data   <= head_data;
                        w_mask   <= head_mask;
                        attempts <= CNT_W'(1);
                        if (head_op == CMD_RSVD) begin
                            // Reserved opcode: report an error without touching the bus.
                            state       <= ST_RESP;
                            RSP_VALID   <= 1'b1;
                            RSP_DATA    <= '0;
                            RSP_ERR     <= 1'b1;
                            RSP_TIMEOUT <= 1'b0;
                        end else begin
                            state  <= ST_ADDR;
                            HTRANS <= HTRANS_NONSEQ;
                            HADDR  <= head_addr;
                            HSEL   <= SEL_ONE << head_addr[ADDR_WIDTH-1 -: SW];
                            HWRITE <= (head_op == CMD_WRITE);
                        end
                    end
                end
                ST_ADDR: begin
                    state  <= ST_DATA;
                    HTRANS <= HTRANS_IDLE;
                    HWDATA <= (w_op == CMD_WRITE) ? w_data : '0;
                end
                ST_DATA: begin
                    if (HREADY) begin
                        if (poll_retry) begin
                            attempts <= attempts + 1'b1;
                            state    <= ST_ADDR;
                            HTRANS   <= HTRANS_NONSEQ;
                        end else begin
                            // A poll that reaches here unmatched and error-free
                            // has used its final attempt.
                            state       <= ST_RESP;
                            RSP_VALID   <= 1'b1;
                            RSP_DATA    <= (w_op == CMD_WRITE) ? '0 : HRDATA;
                            RSP_ERR     <= HRESP;
                            RSP_TIMEOUT <= (w_op == CMD_POLL) && !poll_match && !HRESP;
                        end
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    RSP_DATA    <= '0;
                    RSP_ERR     <= 1'b0;
                    RSP_TIMEOUT <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_cmd_master.sv
module tb_ahbl_cmd_master;

    logic        SYSCLK = 1'b0;
    logic        SYSRST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [31:0] CMD_ADDR;
    logic [31:0] CMD_DATA;
    logic [31:0] CMD_MASK;
    logic        RSP_VALID;
    logic [31:0] RSP_DATA;
    logic        RSP_ERR;
    logic        RSP_TIMEOUT;
    logic        BUSY;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [15:0] HSEL;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahbl_cmd_master #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_SLAVES (16),
        .FIFO_DEPTH (4),
        .POLL_MAX   (3)
    ) dut (
        .SYSCLK      (SYSCLK),
        .SYSRST      (SYSRST),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_OP      (CMD_OP),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_DATA    (CMD_DATA),
        .CMD_MASK    (CMD_MASK),
        .RSP_VALID   (RSP_VALID),
        .RSP_DATA    (RSP_DATA),
        .RSP_ERR     (RSP_ERR),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .BUSY        (BUSY),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HMASTLOCK   (HMASTLOCK),
        .HWDATA      (HWDATA),
        .HSEL        (HSEL),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- response / bus monitor ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        to;
        int          cyc;
    } rsp_t;

    rsp_t rsp_q[$];
    int   nonseq_cnt  = 0;
    int   hsel_viol   = 0;
    int   static_viol = 0;

    always @(negedge SYSCLK) begin
        if (SYSRST === 1'b0) begin
            if (RSP_VALID) rsp_q.push_back('{RSP_DATA, RSP_ERR, RSP_TIMEOUT, cyc});
            if (HTRANS == 2'b10) begin
                nonseq_cnt++;
                if (HSEL !== (16'h0001 << HADDR[31:28])) hsel_viol++;
            end
        end
        if (HBURST !== 3'b000 || HSIZE !== 3'b010 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0)
            static_viol++;
    end

    // ---------------- slave model ----------------
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rd_ovr[$];
    int          fixed_waits = 0;   // -1 selects random 0..2 wait states

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic is_err_addr(input logic [31:0] a);
        return a[31:28] == 4'hE;
    endfunction

    initial begin
        logic [31:0] a;
        logic        w;
        int          nw;
        logic        aborted;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(posedge SYSCLK); #1;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
            if (SYSRST === 1'b0 && HTRANS == 2'b10) begin
                a = HADDR; w = HWRITE;
                nw = (fixed_waits < 0) ? int'($urandom_range(0, 2)) : fixed_waits;
                aborted = 1'b0;
                for (int i = 0; i < nw; i++) begin
                    @(posedge SYSCLK); #1;
                    if (SYSRST) begin aborted = 1'b1; HREADY = 1'b1; break; end
                    HREADY = 1'b0;
                end
                if (!aborted) begin
                    @(posedge SYSCLK); #1;
                    if (is_err_addr(a)) begin
                        HREADY = 1'b0; HRESP = 1'b1;
                        @(posedge SYSCLK); #1;
                        HREADY = 1'b1; HRESP = 1'b1;
                    end else begin
                        HREADY = 1'b1;
                        if (w) smem[a] = HWDATA;
                        else if (rd_ovr.size() > 0) HRDATA = rd_ovr.pop_front();
                        else HRDATA = smem.exists(a) ? smem[a] : dflt(a);
                    end
                end
            end
        end
    end

    // ---------------- reference model (random phase) ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        to;
    } exp_t;

    logic [31:0] mmem [logic [31:0]];

    function automatic logic [31:0] peek(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : dflt(a);
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] d, input logic [31:0] m);
        exp_t        r;
        logic [31:0] v;
        logic        e;
        v = peek(a);
        e = is_err_addr(a);
        r = '{32'h0, 1'b0, 1'b0};
        case (op)
            2'b00: begin if (!e) mmem[a] = d; r.err = e; end
            2'b01: begin r.data = e ? 32'h0 : v; r.err = e; end
            2'b10: begin
                if (e) r.err = 1'b1;
                else begin
                    r.data = v;
                    r.to   = ((v & m) != (d & m));  // memory is static during a poll
                end
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic push_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] m, output int acc);
        int g;
        g = 0;
        @(negedge SYSCLK);
        while (!CMD_READY && g < 200) begin @(negedge SYSCLK); g++; end
        check("push_ready_wait", 32'(CMD_READY), 32'd1);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_ADDR = a; CMD_DATA = d; CMD_MASK = m;
        acc = cyc;
        @(negedge SYSCLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int g;
        g = 0;
        while (int'(rsp_q.size()) < n && g < budget) begin @(posedge SYSCLK); g++; end
        check("rsp_wait_bound", 32'(int'(rsp_q.size()) >= n), 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string            name;
        logic [1:0]       op;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [31:0]      mask;
        int               waits;
        int               novr;
        logic [2:0][31:0] ovr;
        logic [31:0]      exp_data;
        logic             exp_err;
        logic             exp_to;
        int               exp_lat;
        int               exp_ns;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] m, input int w,
                                input int no, input logic [31:0] o0, input logic [31:0] o1,
                                input logic [31:0] o2, input logic [31:0] ed, input logic ee,
                                input logic et, input int lat, input int ns);
        vec_t v;
        v.name = nm; v.op = op; v.addr = a; v.data = d; v.mask = m; v.waits = w;
        v.novr = no; v.ovr[0] = o0; v.ovr[1] = o1; v.ovr[2] = o2;
        v.exp_data = ed; v.exp_err = ee; v.exp_to = et; v.exp_lat = lat; v.exp_ns = ns;
        return v;
    endfunction

    vec_t vt[8];

    initial begin
        int   acc;
        int   base;
        int   ns0;
        rsp_t r;
        logic rdy [5];
        exp_t exp_q[$];

        vt[0] = mk("wr_zero_wait", 2'b00, 32'h3000_0010, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 4, 1);
        vt[1] = mk("rd_3_waits",   2'b01, 32'h1000_0004, 0, 0, 3, 1, 32'h1234_5678, 0, 0, 32'h1234_5678, 0, 0, 7, 1);
        vt[2] = mk("rd_back",      2'b01, 32'h3000_0010, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 4, 1);
        vt[3] = mk("poll_match3",  2'b10, 32'h2000_0000, 32'h1, 32'h1, 0, 3, 0, 0, 1, 32'h1, 0, 0, 8, 3);
        vt[4] = mk("poll_timeout", 2'b10, 32'h2000_0000, 32'h1, 32'h1, 0, 3, 0, 0, 0, 32'h0, 0, 1, 8, 3);
        vt[5] = mk("wr_hresp_err", 2'b00, 32'hE000_0000, 32'h55, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 5, 1);
        vt[6] = mk("reserved_op",  2'b11, 32'h5000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0, 2, 0);
        vt[7] = mk("poll_match1",  2'b10, 32'h6000_0008, 32'h0000_AB00, 32'h0000_FF00, 1, 1,
                   32'h0012_AB34, 0, 0, 32'h0012_AB34, 0, 0, 5, 1);

        SYSRST = 1'b1; CMD_VALID = 1'b0; CMD_OP = '0; CMD_ADDR = '0; CMD_DATA = '0; CMD_MASK = '0;
        repeat (3) @(negedge SYSCLK);
        SYSRST = 1'b0;
        @(negedge SYSCLK);
        check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst_rsp_data",  RSP_DATA, 32'd0);
        check("rst_busy",      32'(BUSY), 32'd0);
        check("rst_htrans",    32'(HTRANS), 32'd0);
        check("rst_haddr",     HADDR, 32'd0);
        check("rst_hsel",      32'(HSEL), 32'd0);
        check("rst_hwrite",    32'(HWRITE), 32'd0);
        check("rst_hwdata",    HWDATA, 32'd0);

        // Cycle-exact zero-wait write.
        fixed_waits = 0;
        base = rsp_q.size();
        push_cmd(2'b00, 32'h3000_0010, 32'hDEAD_BEEF, 0, acc);
        check("seq_busy_after_accept", 32'(BUSY), 32'd1);
        @(negedge SYSCLK);
        check("seq_n2_cycle",  32'(cyc - acc), 32'd2);
        check("seq_n2_htrans", 32'(HTRANS), 32'h2);
        check("seq_n2_haddr",  HADDR, 32'h3000_0010);
        check("seq_n2_hsel",   32'(HSEL), 32'h0008);
        check("seq_n2_hwrite", 32'(HWRITE), 32'd1);
        @(negedge SYSCLK);
        check("seq_n3_htrans", 32'(HTRANS), 32'h0);
        check("seq_n3_hwdata", HWDATA, 32'hDEAD_BEEF);
        @(negedge SYSCLK);
        check("seq_n4_rsp_valid", 32'(RSP_VALID), 32'd1);
        check("seq_n4_rsp_err",   32'(RSP_ERR), 32'd0);
        @(negedge SYSCLK);
        check("seq_n5_rsp_pulse", 32'(RSP_VALID), 32'd0);

        // Table-driven directed vectors.
        for (int i = 0; i < 8; i++) begin
            fixed_waits = vt[i].waits;
            rd_ovr.delete();
            for (int k = 0; k < vt[i].novr; k++) rd_ovr.push_back(vt[i].ovr[k]);
            base = rsp_q.size();
            ns0  = nonseq_cnt;
            push_cmd(vt[i].op, vt[i].addr, vt[i].data, vt[i].mask, acc);
            wait_rsp(base + 1, 80);
            repeat (3) @(posedge SYSCLK);
            if (int'(rsp_q.size()) > base) begin
                r = rsp_q[base];
                check({vt[i].name, "_data"}, r.data, vt[i].exp_data);
                check({vt[i].name, "_err"},  32'(r.err), 32'(vt[i].exp_err));
                check({vt[i].name, "_to"},   32'(r.to), 32'(vt[i].exp_to));
                check({vt[i].name, "_lat"},  32'(r.cyc - acc), 32'(vt[i].exp_lat));
            end
            check({vt[i].name, "_nonseq"}, 32'(nonseq_cnt - ns0), 32'(vt[i].exp_ns));
            check({vt[i].name, "_rsp_count"}, 32'(int'(rsp_q.size()) - base), 32'd1);
        end

        // Error write followed by a queued read: the read still runs.
        fixed_waits = 0;
        rd_ovr.delete();
        base = rsp_q.size();
        push_cmd(2'b00, 32'hE000_0004, 32'h1, 0, acc);
        push_cmd(2'b01, 32'h3000_0010, 0, 0, acc);
        wait_rsp(base + 2, 80);
        if (int'(rsp_q.size()) >= base + 2) begin
            check("err_then_next_err0", 32'(rsp_q[base].err), 32'd1);
            check("err_then_next_err1", 32'(rsp_q[base+1].err), 32'd0);
            check("err_then_next_data", rsp_q[base+1].data, 32'hDEAD_BEEF);
        end

        // Queue fill while the slave stalls the first transfer.
        repeat (3) @(negedge SYSCLK);
        fixed_waits = 15;
        base = rsp_q.size();
        push_cmd(2'b01, 32'h4000_0100, 0, 0, acc);
        for (int i = 0; i < 5; i++) begin
            CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_ADDR = 32'h4000_0104 + 32'(4 * i);
            rdy[i] = CMD_READY;
            if (i < 4) @(negedge SYSCLK);
        end
        fixed_waits = 1;
        begin
            int g;
            g = 0;
            while (!CMD_READY && g < 200) begin @(negedge SYSCLK); g++; end
        end
        @(negedge SYSCLK);
        CMD_VALID = 1'b0;
        for (int i = 0; i < 5; i++)
            check($sformatf("fill_ready_offer%0d", i), 32'(rdy[i]), (i < 4) ? 32'd1 : 32'd0);
        wait_rsp(base + 6, 400);
        for (int i = 0; i < 6; i++)
            if (int'(rsp_q.size()) > base + i)
                check($sformatf("fill_order%0d", i), rsp_q[base+i].data, dflt(32'h4000_0100 + 32'(4 * i)));

        // Reset during a stalled data phase with another command queued.
        repeat (3) @(negedge SYSCLK);
        fixed_waits = 50;
        push_cmd(2'b01, 32'h4000_0200, 0, 0, acc);
        push_cmd(2'b00, 32'h4000_0204, 32'h77, 0, acc);
        check("rstmid_in_data", 32'(HTRANS == 2'b00 && BUSY), 32'd1);
        base = rsp_q.size();
        SYSRST = 1'b1;
        @(negedge SYSCLK);
        check("rstmid_htrans", 32'(HTRANS), 32'd0);
        check("rstmid_busy",   32'(BUSY), 32'd0);
        check("rstmid_rsp",    32'(RSP_VALID), 32'd0);
        check("rstmid_ready",  32'(CMD_READY), 32'd1);
        SYSRST = 1'b0;
        fixed_waits = 0;
        ns0 = nonseq_cnt;
        repeat (10) @(negedge SYSCLK);
        check("rstmid_no_rsp",    32'(int'(rsp_q.size()) - base), 32'd0);
        check("rstmid_no_nonseq", 32'(nonseq_cnt - ns0), 32'd0);
        check("rstmid_idle_busy", 32'(BUSY), 32'd0);

        // Randomised commands against the reference model.
        smem.delete();
        mmem.delete();
        fixed_waits = -1;
        base = rsp_q.size();
        begin
            int          sent;
            int          g;
            logic [3:0]  nib;
            logic [1:0]  op;
            logic [31:0] a, d, m;
            int          rop;
            sent = 0; g = 0;
            while (sent < 60 && g < 3000) begin
                @(negedge SYSCLK); g++;
                rop = int'($urandom_range(0, 9));
                op  = (rop < 3) ? 2'b00 : (rop < 6) ? 2'b01 : (rop < 9) ? 2'b10 : 2'b11;
                case ($urandom_range(0, 7))
                    0: nib = 4'hE;
                    1, 2: nib = 4'h1;
                    3, 4: nib = 4'h2;
                    default: nib = 4'h6;
                endcase
                a = {nib, 28'h0} | (32'($urandom_range(0, 3)) << 2);
                d = $urandom;
                m = $urandom;
                if (op == 2'b10 && $urandom_range(0, 1) == 1) d = peek(a);
                CMD_VALID = ($urandom_range(0, 3) != 0);
                CMD_OP = op; CMD_ADDR = a; CMD_DATA = d; CMD_MASK = m;
                if (CMD_VALID && CMD_READY) begin
                    exp_q.push_back(model(op, a, d, m));
                    sent++;
                end
            end
            @(negedge SYSCLK);
            CMD_VALID = 1'b0;
            check("rand_sent", 32'(sent), 32'd60);
        end
        wait_rsp(base + exp_q.size(), 3000);
        repeat (3) @(posedge SYSCLK);
        check("rand_rsp_count", 32'(int'(rsp_q.size()) - base), 32'(exp_q.size()));
        for (int i = 0; i < int'(exp_q.size()); i++) begin
            if (int'(rsp_q.size()) > base + i) begin
                check($sformatf("rand%0d_data", i), rsp_q[base+i].data, exp_q[i].data);
                check($sformatf("rand%0d_err", i),  32'(rsp_q[base+i].err), 32'(exp_q[i].err));
                check($sformatf("rand%0d_to", i),   32'(rsp_q[base+i].to), 32'(exp_q[i].to));
            end
        end

        check("hsel_decode_viol", 32'(hsel_viol), 32'd0);
        check("static_ahb_viol",  32'(static_viol), 32'd0);
        check("final_busy",       32'(BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
